// File: rtl/interrupt_arbiter.sv
// rtl/interrupt_arbiter.sv - 8-source falling-edge interrupt arbiter with bus registers; define INTERRUPT_ARBITER_ROUND_ROBIN_EN for round-robin selection
module interrupt_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  irq_n,
    output logic        cpu_irq,
    output logic [2:0]  cpu_irq_vector,
    input  logic        cpu_irq_ack,
    input  logic        cpu_irq_done,
    input  logic [15:0] data_bus_write,
    output logic [15:0] data_bus_read,
    input  logic [31:0] data_bus_addr,
    input  logic [1:0]  data_bus_mode,
    input  logic        data_bus_select
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQUEST = 2'b01,
        ST_SERVICE = 2'b10,
        ST_UNUSED  = 2'b11
    } state_t;

    localparam logic [31:0] ADDR_MASK    = BASE_ADDR;
    localparam logic [31:0] ADDR_PENDING = BASE_ADDR + 32'd4;
    localparam logic [31:0] ADDR_ACTIVE  = BASE_ADDR + 32'd8;
    localparam logic [31:0] ADDR_STATUS  = BASE_ADDR + 32'd12;

    state_t      state_q;
    logic [7:0]  mask_q;
    logic [7:0]  mask_d;
    logic [7:0]  pending_q;
    logic [7:0]  pending_d;
    logic [7:0]  active_q;
    logic [2:0]  rr_ptr_q;
    logic [2:0]  vector_q;
    logic        cpu_irq_q;
    logic [7:0]  irq_prev_q;
    logic        armed_q;

    logic        wr_en;
    logic        wr_mask;
    logic        wr_pending;
    logic        wr_active;
    logic        force_done;
    logic        ack_take;
    logic [7:0]  edges;
    logic [7:0]  vec_onehot;
    logic [7:0]  clr_bits;
    logic [7:0]  eligible;
    logic [2:0]  win_idx;

    assign cpu_irq        = cpu_irq_q;
    assign cpu_irq_vector = vector_q;

    // Bus write decode; only mode 10 with select counts as a write
    always_comb begin
        wr_en      = data_bus_select && (data_bus_mode == 2'b10);
        wr_mask    = wr_en && (data_bus_addr == ADDR_MASK);
        wr_pending = wr_en && (data_bus_addr == ADDR_PENDING);
        wr_active  = wr_en && (data_bus_addr == ADDR_ACTIVE);
        force_done = wr_active && (data_bus_write == 16'h0000);
    end

    // Register read mux, purely combinational from the address
    always_comb begin
        data_bus_read = 16'h0000;
        if (data_bus_addr == ADDR_MASK) begin
            data_bus_read = {8'h00, mask_q};
        end else if (data_bus_addr == ADDR_PENDING) begin
            data_bus_read = {8'h00, pending_q};
        end else if (data_bus_addr == ADDR_ACTIVE) begin
            data_bus_read = {8'h00, active_q};
        end else if (data_bus_addr == ADDR_STATUS) begin
            data_bus_read = {8'h00, rr_ptr_q, vector_q, state_q};
        end
    end

    // Next values of MASK and PENDING; a new edge beats any clear in the same cycle
    always_comb begin
        // The first cycle after reset only loads irq_prev, so a line already
        // low when reset releases is not mistaken for a fresh falling edge.
        edges      = armed_q ? (irq_prev_q & ~irq_n) : 8'h00;
        ack_take   = (state_q == ST_REQUEST) && cpu_irq_ack;
        vec_onehot = 8'b0000_0001 << vector_q;
        clr_bits   = (wr_pending ? data_bus_write[7:0] : 8'h00)
                   | (ack_take ? vec_onehot : 8'h00);
        pending_d  = (pending_q & ~clr_bits) | edges;
        mask_d     = wr_mask ? data_bus_write[7:0] : mask_q;
        eligible   = pending_q & mask_q;
    end

`ifdef INTERRUPT_ARBITER_ROUND_ROBIN_EN
    logic       win_found;
    logic [2:0] scan_idx;

    // Round-robin winner: first eligible source at or above rr_ptr, wrapping 7->0
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        scan_idx  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            scan_idx = rr_ptr_q + 3'(i);
            if (!win_found && eligible[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end
`else
    // Fixed-priority winner: lowest eligible index
    always_comb begin
        win_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (eligible[i]) begin
                win_idx = 3'(i);
            end
        end
    end
`endif

    // Edge-detect history, PENDING and MASK storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_prev_q <= 8'hFF;
            armed_q    <= 1'b0;
            pending_q  <= 8'h00;
            mask_q     <= 8'h00;
        end else begin
            irq_prev_q <= irq_n;
            armed_q    <= 1'b1;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
        end
    end

    // Request/service FSM with registered cpu_irq, vector, ACTIVE and rr_ptr
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            vector_q  <= 3'd0;
            cpu_irq_q <= 1'b0;
            active_q  <= 8'h00;
            rr_ptr_q  <= 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|eligible) begin
                        vector_q  <= win_idx;
                        state_q   <= ST_REQUEST;
                        cpu_irq_q <= 1'b1;
                    end
                end
                ST_REQUEST: begin
                    // Ack takes precedence over a withdrawal and over done
                    if (cpu_irq_ack) begin
                        active_q  <= vec_onehot;
                        state_q   <= ST_SERVICE;
                        cpu_irq_q <= 1'b0;
                    end else if (!(pending_d[vector_q] && mask_d[vector_q])) begin
                        state_q   <= ST_IDLE;
                        cpu_irq_q <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (cpu_irq_done || force_done) begin
                        active_q <= 8'h00;
                        rr_ptr_q <= vector_q + 3'd1;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    cpu_irq_q <= 1'b0;
                    active_q  <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_arbiter.sv
// tb/tb_interrupt_arbiter.sv - directed self-checking bench for interrupt_arbiter
module tb_interrupt_arbiter;

    localparam logic [31:0] BASE = 32'h4000;
    localparam logic [31:0] OFF_MASK = 32'd0;
    localparam logic [31:0] OFF_PEND = 32'd4;
    localparam logic [31:0] OFF_ACT  = 32'd8;
    localparam logic [31:0] OFF_STAT = 32'd12;

    logic        clk;
    logic        reset;
    logic [7:0]  irq_n;
    logic        cpu_irq;
    logic [2:0]  cpu_irq_vector;
    logic        cpu_irq_ack;
    logic        cpu_irq_done;
    logic [15:0] data_bus_write;
    logic [15:0] data_bus_read;
    logic [31:0] data_bus_addr;
    logic [1:0]  data_bus_mode;
    logic        data_bus_select;

    int checks;
    int failures;

    interrupt_arbiter #(.BASE_ADDR(BASE)) dut (
        .clk             (clk),
        .reset           (reset),
        .irq_n           (irq_n),
        .cpu_irq         (cpu_irq),
        .cpu_irq_vector  (cpu_irq_vector),
        .cpu_irq_ack     (cpu_irq_ack),
        .cpu_irq_done    (cpu_irq_done),
        .data_bus_write  (data_bus_write),
        .data_bus_read   (data_bus_read),
        .data_bus_addr   (data_bus_addr),
        .data_bus_mode   (data_bus_mode),
        .data_bus_select (data_bus_select)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] off, input logic [15:0] data);
        data_bus_addr   = BASE + off;
        data_bus_write  = data;
        data_bus_mode   = 2'b10;
        data_bus_select = 1'b1;
        tick();
        data_bus_mode   = 2'b00;
        data_bus_select = 1'b0;
        data_bus_write  = 16'h0000;
    endtask

    task automatic chk_reg(input string tag, input logic [31:0] off, input logic [15:0] exp);
        data_bus_addr = BASE + off;
        data_bus_mode = 2'b01;
        data_bus_select = 1'b1;
        #1;
        check_eq(tag, {16'h0, data_bus_read}, {16'h0, exp});
        data_bus_mode = 2'b00;
        data_bus_select = 1'b0;
    endtask

    task automatic pulse_ack();
        cpu_irq_ack = 1'b1;
        tick();
        cpu_irq_ack = 1'b0;
    endtask

    task automatic pulse_done();
        cpu_irq_done = 1'b1;
        tick();
        cpu_irq_done = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        irq_n = 8'hFF;
        cpu_irq_ack = 1'b0;
        cpu_irq_done = 1'b0;
        data_bus_write = 16'h0;
        data_bus_addr = 32'h0;
        data_bus_mode = 2'b00;
        data_bus_select = 1'b0;

        // Reset state
        repeat (2) tick();
        check_eq("rst_cpu_irq", {31'h0, cpu_irq}, 32'h0);
        chk_reg("rst_mask", OFF_MASK, 16'h0000);
        chk_reg("rst_pend", OFF_PEND, 16'h0000);
        chk_reg("rst_act", OFF_ACT, 16'h0000);
        chk_reg("rst_stat", OFF_STAT, 16'h0000);
        reset = 1'b0;
        repeat (2) tick();

        // Basic single-source flow and latency
        bus_write(OFF_MASK, 16'h0001);
        chk_reg("mask_rw", OFF_MASK, 16'h0001);
        chk_reg("unmapped", 32'h10, 16'h0000);
        irq_n = 8'hFE;
        tick();
        chk_reg("lat_pend_n1", OFF_PEND, 16'h0001);
        check_eq("lat_irq_n1", {31'h0, cpu_irq}, 32'h0);
        tick();
        check_eq("lat_irq_n2", {31'h0, cpu_irq}, 32'h1);
        check_eq("lat_vec_n2", {29'h0, cpu_irq_vector}, 32'h0);
        chk_reg("stat_request", OFF_STAT, 16'h0001);
        pulse_ack();
        chk_reg("ack_active", OFF_ACT, 16'h0001);
        chk_reg("ack_pend", OFF_PEND, 16'h0000);
        check_eq("ack_irq_low", {31'h0, cpu_irq}, 32'h0);
        chk_reg("stat_service", OFF_STAT, 16'h0002);
        pulse_done();
        chk_reg("done_act", OFF_ACT, 16'h0000);
        chk_reg("done_stat", OFF_STAT, 16'h0020);
        repeat (2) tick();
        chk_reg("held_low_no_repend", OFF_PEND, 16'h0000);
        check_eq("held_low_irq", {31'h0, cpu_irq}, 32'h0);
        irq_n = 8'hFF;
        tick();

        // Two simultaneous sources 2 and 5
        bus_write(OFF_MASK, 16'h00FF);
        irq_n = 8'hDB;
        tick();
        chk_reg("dual_pend", OFF_PEND, 16'h0024);
        tick();
        check_eq("dual_vec_a", {29'h0, cpu_irq_vector}, 32'h2);
        check_eq("dual_irq_a", {31'h0, cpu_irq}, 32'h1);
        pulse_ack();
        chk_reg("dual_pend_after_ack", OFF_PEND, 16'h0020);
        pulse_done();
        chk_reg("dual_stat_rr3", OFF_STAT, 16'h0068);
        tick();
        check_eq("dual_vec_b", {29'h0, cpu_irq_vector}, 32'h5);
        check_eq("dual_irq_b", {31'h0, cpu_irq}, 32'h1);
        pulse_ack();
        pulse_done();
        chk_reg("dual_stat_rr6", OFF_STAT, 16'h00D4);
        irq_n = 8'hFF;
        tick();

        // Sources 0 and 6 with rr_ptr = 6
        irq_n = 8'hBE;
        tick();
        chk_reg("rr_pend", OFF_PEND, 16'h0041);
        tick();
`ifdef INTERRUPT_ARBITER_ROUND_ROBIN_EN
        check_eq("rr_vec_a", {29'h0, cpu_irq_vector}, 32'h6);
`else
        check_eq("fp_vec_a", {29'h0, cpu_irq_vector}, 32'h0);
`endif
        pulse_ack();
        pulse_done();
`ifdef INTERRUPT_ARBITER_ROUND_ROBIN_EN
        chk_reg("rr_stat_a", OFF_STAT, 16'h00F8);
`else
        chk_reg("fp_stat_a", OFF_STAT, 16'h0020);
`endif
        tick();
`ifdef INTERRUPT_ARBITER_ROUND_ROBIN_EN
        check_eq("rr_vec_b", {29'h0, cpu_irq_vector}, 32'h0);
`else
        check_eq("fp_vec_b", {29'h0, cpu_irq_vector}, 32'h6);
`endif
        pulse_ack();
        pulse_done();
        irq_n = 8'hFF;
        tick();

        // Withdraw from REQUEST by W1C of the requested bit
        irq_n = 8'hF7;
        repeat (2) tick();
        check_eq("wd_vec", {29'h0, cpu_irq_vector}, 32'h3);
        check_eq("wd_irq_before", {31'h0, cpu_irq}, 32'h1);
        bus_write(OFF_PEND, 16'h0008);
        check_eq("wd_irq_after", {31'h0, cpu_irq}, 32'h0);
        chk_reg("wd_stat", OFF_STAT, 16'h0000 | (16'h3 << 2) | (16'(dut.rr_ptr_q) << 5));
        chk_reg("wd_act", OFF_ACT, 16'h0000);
        chk_reg("wd_pend", OFF_PEND, 16'h0000);
        irq_n = 8'hFF;
        tick();

        // Forced completion via ACTIVE write, then edge + W1C collision
        irq_n = 8'hEF;
        repeat (2) tick();
        check_eq("fc_vec", {29'h0, cpu_irq_vector}, 32'h4);
        pulse_ack();
        chk_reg("fc_act", OFF_ACT, 16'h0010);
        bus_write(OFF_ACT, 16'h0001);
        chk_reg("fc_nonzero_ignored", OFF_ACT, 16'h0010);
        bus_write(OFF_ACT, 16'h0000);
        chk_reg("fc_act_clr", OFF_ACT, 16'h0000);
        chk_reg("fc_stat", OFF_STAT, 16'h00B0);
        irq_n = 8'hFF;
        tick();
        irq_n = 8'hEF;
        bus_write(OFF_PEND, 16'h0010);
        chk_reg("set_wins", OFF_PEND, 16'h0010);
        tick();
        check_eq("sw_irq", {31'h0, cpu_irq}, 32'h1);
        cpu_irq_ack = 1'b1;
        cpu_irq_done = 1'b1;
        tick();
        cpu_irq_ack = 1'b0;
        cpu_irq_done = 1'b0;
        chk_reg("ack_wins_act", OFF_ACT, 16'h0010);
        pulse_ack();
        chk_reg("ack_ignored_service", OFF_STAT, 16'h00B2);
        pulse_done();
        irq_n = 8'hFF;
        tick();
        pulse_ack();
        chk_reg("ack_ignored_idle", OFF_ACT, 16'h0000);

        // Reset during SERVICE with source held low across release
        irq_n = 8'hFD;
        repeat (2) tick();
        pulse_ack();
        chk_reg("pre_rst_act", OFF_ACT, 16'h0002);
        #3;
        reset = 1'b1;
        #1;
        check_eq("arst_irq", {31'h0, cpu_irq}, 32'h0);
        chk_reg("arst_act", OFF_ACT, 16'h0000);
        chk_reg("arst_mask", OFF_MASK, 16'h0000);
        chk_reg("arst_stat", OFF_STAT, 16'h0000);
        check_eq("arst_prev", {24'h0, dut.irq_prev_q}, 32'hFF);
        tick();
        reset = 1'b0;
        bus_write(OFF_MASK, 16'h00FF);
        repeat (3) tick();
        chk_reg("post_rst_pend", OFF_PEND, 16'h0000);
        check_eq("post_rst_irq", {31'h0, cpu_irq}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
